heap_level_ram: RTL
===================

Name: heap_level_ram

Overview:
Parametrised true dual-port storage for one heap level, the successor to the plain per-level dpram.
- Adds a post-reset clear sequencer, explicit read enables with read-valid outputs, a selectable read-during-write mode, and a defined write-collision policy with a collision flag.
- One instance per heap level; the sorter control FSM drives port A and the sift pipeline drives port B.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 5, address port width; only the low LEVEL bits index memory.
- LEVEL, 1, heap level; depth MEM_SIZE = 1<<LEVEL. LEVEL=0 gives a single register.
- RDW_MODE, 0, read-during-write result: 0 = read-first (old data), 1 = write-first (new data).
- WR_PRIO, 0, winning port on same-address dual write: 0 = A, 1 = B.
- INIT_VAL, 0, value written to every entry after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- init_done  out  1  high once clearing is complete; requests are ignored while low
- en_a  in  1  port A access enable
- we_a  in  1  port A write (qualified by en_a)
- addr_a  in  ADDR_WIDTH  port A address
- data_a  in  DATA_WIDTH  port A write data
- q_a  out  DATA_WIDTH  port A read data
- qv_a  out  1  port A read valid
- en_b, we_b, addr_b, data_b, q_b, qv_b: same as port A, for port B
- collision  out  1  one-cycle pulse after a same-address dual write
- perr_a, perr_b  out  1  parity error flags (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - q_a = q_b = 0; qv_a = qv_b = 0; collision = 0; perr_a = perr_b = 0; init_done = 0.
  - Sequencer enters INIT with its counter at 0.
- FSM:
  - INIT: writes INIT_VAL to entry cnt each cycle; cnt increments. When cnt = MEM_SIZE-1, that entry is written and the FSM moves to RUN.
  - RUN: init_done = 1 from the cycle after the last clear write. INIT therefore lasts MEM_SIZE cycles.
  - RUN is terminal until rst.
- Access in INIT: en_a/en_b are ignored and qv stays 0.
- Access in RUN:
  - An access occurs when en_x = 1. Read latency is 1 cycle: q_x and qv_x are updated on the clock edge after the request.
  - qv_x = 1 for exactly one cycle per accepted enable, including writes; q_x returns the read-during-write value.
  - q_x holds its value while en_x = 0.
- Same-port read-during-write: RDW_MODE=0 gives the old entry value; RDW_MODE=1 gives data_x.
- Cross-port: port X writes address N while port Y accesses N in the same cycle:
  - q_y follows RDW_MODE (old value or data_x).
  - If Y is also writing, the dual-write rule below applies.
- Dual write, same address:
  - The WR_PRIO port's data is stored.
  - Both q outputs return the stored winner in write-first mode, or the old value in read-first mode.
  - collision = 1 in the next cycle only.
- Dual write, different addresses: both writes complete; no collision.
- Address wrap: addr bits at or above LEVEL are ignored (addr mod MEM_SIZE).
- LEVEL=0: a single register; INIT is 1 cycle; all addresses alias.
- Reset mid-operation: in-flight reads are discarded (qv = 0), the FSM restarts INIT, and the full clear is repeated.

Optional Feature:
- Macro: HEAP_RAM_PARITY_EN.
- Enabled:
  - Each entry stores an extra even-parity bit computed on write (including INIT writes).
  - On read, perr_x = qv_x & (stored parity != parity of stored data). It is also a 1-cycle pulse.
  - A hidden bench hook, force_bad_par (a bench-only hierarchical reg, not a port), inverts the parity bit on the next write.
- Disabled: no parity storage; perr_a and perr_b are tied to 0.

Decomposition:
- Package heap_ram_pkg holds:
  - localparams RDW_READ_FIRST=0, RDW_WRITE_FIRST=1, PRIO_A=0, PRIO_B=1;
  - typedef heap_ram_state_t {ST_INIT, ST_RUN};
  - function even_par(data).
- Sub-module heap_ram_init_seq: the INIT/RUN FSM plus the clear counter, with outputs clr_we, clr_addr, init_done.
- The top level muxes clear writes onto port A and implements the storage, bypass, and collision logic.

Test Plan:
- LEVEL=3, rst for 2 cycles, then idle: init_done rises exactly 8 cycles after rst falls; reads of addr 0..7 all return INIT_VAL=0 with qv pulses.
- RUN, A writes addr 5 = 0xDEADBEEF, then the next cycle B reads addr 5: q_b = 0xDEADBEEF and qv_b = 1 one cycle later.
- A writes addr 2 = 0x11 and B reads addr 2 in the same cycle, old value 0x7:
  - RDW_MODE=0 gives q_b = 0x7.
  - RDW_MODE=1 gives q_b = 0x11.
- A writes 0xAA and B writes 0xBB to addr 4 in the same cycle:
  - With WR_PRIO=0, collision pulses once and a later read gives 0xAA.
  - With WR_PRIO=1, the later read gives 0xBB.
- addr_a = 0x1D with LEVEL=3: the access hits entry 5; writes issued during INIT are dropped and the entry reads INIT_VAL.
- Assert rst mid-traffic: qv is 0 the next cycle, init_done drops, and the memory is re-cleared. With HEAP_RAM_PARITY_EN, a forced bad parity write followed by a read gives a perr pulse aligned with qv.

Source files
------------

// File: rtl/heap_ram_pkg.sv
// Shared constants, sequencer state type and parity helper for heap_level_ram.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package heap_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int PRIO_A          = 0;
    localparam int PRIO_B          = 1;

    // Widest word the parity helper covers; callers zero-extend into it.
    localparam int PAR_MAX_W = 256;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } heap_ram_state_t;

    function automatic logic even_par(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/heap_ram_init_seq.sv
// Post-reset clear sequencer: walks every entry once, then parks in RUN.
// Latency: one clear write per cycle, init_done rises after MEM_SIZE cycles.
// Backpressure: none; the clear cannot be stalled and RUN is terminal until rst.
module heap_ram_init_seq
    import heap_ram_pkg::*;
#(
    parameter  int LEVEL = 1,
    localparam int IDX_W = (LEVEL > 0) ? LEVEL : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_addr,
    output logic             init_done
);

    localparam int MEM_SIZE = 1 << LEVEL;

    heap_ram_state_t  state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        init_done = 1'b0;
        case (state)
            ST_INIT: begin
                clr_we = 1'b1;
                if (cnt == IDX_W'(MEM_SIZE - 1)) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                init_done = 1'b1;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/heap_level_ram.sv
// True dual-port heap-level store with post-reset clear, RDW bypass and collision flag; parity via HEAP_RAM_PARITY_EN.
// Latency: 1 cycle from en_x to q_x/qv_x; clear takes 1<<LEVEL cycles after rst.
// Backpressure: none; requests are dropped while init_done is low, otherwise always accepted.
module heap_level_ram
    import heap_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    LEVEL      = 1,
    parameter int                    RDW_MODE   = 0,
    parameter int                    WR_PRIO    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic                  qv_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  qv_b,
    output logic                  collision,
    output logic                  perr_a,
    output logic                  perr_b
);

    localparam int IDX_W = (LEVEL > 0) ? LEVEL : 1;
    // Array sized to the full index range so LEVEL=0 never indexes out of bounds;
    // the spare entry is never addressed.
    localparam int MEM_DECL = 1 << IDX_W;

    logic [DATA_WIDTH-1:0] mem [MEM_DECL];

    logic                  clr_we;
    logic [IDX_W-1:0]      clr_addr;
    logic [IDX_W-1:0]      idx_a, idx_b;
    logic                  acc_a, acc_b, wr_a, wr_b, dual_same;
    logic                  mem_we_a;
    logic [IDX_W-1:0]      mem_idx_a;
    logic [DATA_WIDTH-1:0] mem_dat_a, win_dat;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;
    logic                  unused_addr;

    heap_ram_init_seq #(
        .LEVEL (LEVEL)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (init_done)
    );

    // Upper address bits alias onto the same entries.
    assign idx_a       = (LEVEL == 0) ? '0 : addr_a[IDX_W-1:0];
    assign idx_b       = (LEVEL == 0) ? '0 : addr_b[IDX_W-1:0];
    assign unused_addr = ^{addr_a, addr_b};

    assign acc_a     = init_done & en_a;
    assign acc_b     = init_done & en_b;
    assign wr_a      = acc_a & we_a;
    assign wr_b      = acc_b & we_b;
    assign dual_same = wr_a & wr_b & (idx_a == idx_b);
    assign win_dat   = (WR_PRIO == PRIO_B) ? data_b : data_a;

    // The clear sequencer borrows port A's write path until RUN.
    assign mem_we_a  = init_done ? wr_a   : clr_we;
    assign mem_idx_a = init_done ? idx_a  : clr_addr;
    assign mem_dat_a = init_done ? data_a : INIT_VAL;

    always_ff @(posedge clk) begin
        if (dual_same) begin
            mem[idx_a] <= win_dat;
        end else begin
            if (mem_we_a) mem[mem_idx_a] <= mem_dat_a;
            if (wr_b)     mem[idx_b]     <= data_b;
        end
    end

    always_comb begin
        rd_a = mem[idx_a];
        rd_b = mem[idx_b];
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            if (dual_same) begin
                rd_a = win_dat;
                rd_b = win_dat;
            end else begin
                if (wr_a)                        rd_a = data_a;
                else if (wr_b && idx_b == idx_a) rd_a = data_b;
                if (wr_b)                        rd_b = data_b;
                else if (wr_a && idx_a == idx_b) rd_b = data_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_a       <= '0;
            q_b       <= '0;
            qv_a      <= 1'b0;
            qv_b      <= 1'b0;
            collision <= 1'b0;
        end else begin
            qv_a      <= acc_a;
            qv_b      <= acc_b;
            collision <= dual_same;
            if (acc_a) q_a <= rd_a;
            if (acc_b) q_b <= rd_b;
        end
    end

`ifdef HEAP_RAM_PARITY_EN
    // Driven only from a testbench to plant a bad parity bit on the next write.
    logic force_bad_par;
    logic par_mem [MEM_DECL];
    logic par_wa, par_wb, par_win, rd_par_a, rd_par_b;

    assign par_wa  = even_par(PAR_MAX_W'(mem_dat_a)) ^ force_bad_par;
    assign par_wb  = even_par(PAR_MAX_W'(data_b))    ^ force_bad_par;
    assign par_win = even_par(PAR_MAX_W'(win_dat))   ^ force_bad_par;

    always_ff @(posedge clk) begin
        if (dual_same) begin
            par_mem[idx_a] <= par_win;
        end else begin
            if (mem_we_a) par_mem[mem_idx_a] <= par_wa;
            if (wr_b)     par_mem[idx_b]     <= par_wb;
        end
    end

    // Parity follows the same bypass choice as the data it protects.
    always_comb begin
        rd_par_a = par_mem[idx_a];
        rd_par_b = par_mem[idx_b];
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            if (dual_same) begin
                rd_par_a = par_win;
                rd_par_b = par_win;
            end else begin
                if (wr_a)                        rd_par_a = par_wa;
                else if (wr_b && idx_b == idx_a) rd_par_a = par_wb;
                if (wr_b)                        rd_par_b = par_wb;
                else if (wr_a && idx_a == idx_b) rd_par_b = par_wa;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_a <= 1'b0;
            perr_b <= 1'b0;
        end else begin
            perr_a <= acc_a & (rd_par_a != even_par(PAR_MAX_W'(rd_a)));
            perr_b <= acc_b & (rd_par_b != even_par(PAR_MAX_W'(rd_b)));
        end
    end
`else
    assign perr_a = 1'b0;
    assign perr_b = 1'b0;
`endif

endmodule
